// File: rtl/alu_resp_collector.sv
// ALU response collector: buffers ALU results in a small FIFO
// and keeps saturating statistics on accepted and dropped results.
module alu_resp_collector #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_out,
  input  logic [3:0]                 alu,
  input  logic                       zero,
  input  logic                       carry,
  input  logic                       clr_stats,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [5:0]                 rsp_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty,
  output logic [CNT_W-1:0]           result_count,
  output logic [7:0]                 zero_count,
  output logic [7:0]                 carry_count,
  output logic [7:0]                 drop_count,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);
  localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);

  logic [5:0]       mem_q [DEPTH];
  logic [5:0]       mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] result_count_q, result_count_d;
  logic [7:0]       zero_count_q, zero_count_d;
  logic [7:0]       carry_count_q, carry_count_d;
  logic [7:0]       drop_count_q, drop_count_d;
  logic             overflow_q, overflow_d;

  logic pop;
  logic push;
  logic drop;

  function automatic logic [7:0] sat8(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

  assign empty     = (level_q == '0);
  assign full      = (level_q == LVL_MAX);
  assign rsp_valid = !empty;
  assign rsp_data  = mem_q[rd_ptr_q];
  assign level     = level_q;

  assign result_count = result_count_q;
  assign zero_count   = zero_count_q;
  assign carry_count  = carry_count_q;
  assign drop_count   = drop_count_q;
  assign overflow     = overflow_q;

  // A full FIFO still accepts a push when the head leaves this cycle
  assign pop  = rsp_valid && rsp_ready;
  assign push = valid_out && (!full || pop);
  assign drop = valid_out && full && !pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = {carry, zero, alu};
      wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    result_count_d = result_count_q;
    zero_count_d   = zero_count_q;
    carry_count_d  = carry_count_q;
    drop_count_d   = drop_count_q;
    overflow_d     = overflow_q;
    if (clr_stats) begin
      result_count_d = '0;
      zero_count_d   = '0;
      carry_count_d  = '0;
      drop_count_d   = '0;
      overflow_d     = 1'b0;
    end else begin
      if (push) begin
        if (!(&result_count_q)) begin
          result_count_d = result_count_q + CNT_W'(1);
        end
        if (zero) zero_count_d = sat8(zero_count_q);
        if (carry) carry_count_d = sat8(carry_count_q);
      end
      if (drop) begin
        drop_count_d = sat8(drop_count_q);
        overflow_d   = 1'b1;
      end
    end
  end

  // Storage is not reset; empty masks stale entries
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      result_count_q <= '0;
      zero_count_q   <= '0;
      carry_count_q  <= '0;
      drop_count_q   <= '0;
      overflow_q     <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      result_count_q <= result_count_d;
      zero_count_q   <= zero_count_d;
      carry_count_q  <= carry_count_d;
      drop_count_q   <= drop_count_d;
      overflow_q     <= overflow_d;
    end
  end

endmodule

// File: tb/tb_alu_resp_collector.sv
// Scoreboard bench for alu_resp_collector: a queue model predicts
// FIFO order and statistics, checked every cycle.
module tb_alu_resp_collector;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk;
  logic             reset;
  logic             valid_out;
  logic [3:0]       alu;
  logic             zero;
  logic             carry;
  logic             clr_stats;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [5:0]       rsp_data;
  logic [2:0]       level;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] result_count;
  logic [7:0]       zero_count;
  logic [7:0]       carry_count;
  logic [7:0]       drop_count;
  logic             overflow;

  alu_resp_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_out    (valid_out),
    .alu          (alu),
    .zero         (zero),
    .carry        (carry),
    .clr_stats    (clr_stats),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .level        (level),
    .full         (full),
    .empty        (empty),
    .result_count (result_count),
    .zero_count   (zero_count),
    .carry_count  (carry_count),
    .drop_count   (drop_count),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit init  = 0;

  logic [5:0]  sb_q[$];
  logic [15:0] m_rc;
  logic [7:0]  m_zc, m_cc, m_dc;
  logic        m_ov;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] s8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  task automatic cyc(input logic v, input logic [3:0] a,
                     input logic z, input logic c,
                     input logic rdy, input logic clr,
                     input logic rst);
    bit pop_m, push_m, drop_m;
    int sz;
    valid_out = v;
    alu       = a;
    zero      = z;
    carry     = c;
    rsp_ready = rdy;
    clr_stats = clr;
    reset     = rst;
    #1;
    sz = sb_q.size();
    if (init) begin
      chk("rsp_valid", 32'(rsp_valid), 32'(sz != 0));
      if (sz != 0) chk("rsp_data", 32'(rsp_data), 32'(sb_q[0]));
    end
    pop_m  = (sz != 0) && rdy;
    push_m = v && ((sz < DEPTH) || pop_m);
    drop_m = v && !push_m;
    if (rst) begin
      sb_q.delete();
      m_rc = '0; m_zc = '0; m_cc = '0; m_dc = '0; m_ov = 1'b0;
    end else begin
      if (pop_m) void'(sb_q.pop_front());
      if (push_m) sb_q.push_back({c, z, a});
      if (clr) begin
        m_rc = '0; m_zc = '0; m_cc = '0; m_dc = '0; m_ov = 1'b0;
      end else begin
        if (push_m) begin
          if (m_rc != 16'hFFFF) m_rc = m_rc + 16'd1;
          if (z) m_zc = s8(m_zc);
          if (c) m_cc = s8(m_cc);
        end
        if (drop_m) begin
          m_dc = s8(m_dc);
          m_ov = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    init = 1;
    chk("level", 32'(level), 32'(sb_q.size()));
    chk("full", 32'(full), 32'(sb_q.size() == DEPTH));
    chk("empty", 32'(empty), 32'(sb_q.size() == 0));
    chk("result_count", 32'(result_count), 32'(m_rc));
    chk("zero_count", 32'(zero_count), 32'(m_zc));
    chk("carry_count", 32'(carry_count), 32'(m_cc));
    chk("drop_count", 32'(drop_count), 32'(m_dc));
    chk("overflow", 32'(overflow), 32'(m_ov));
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, 4'bxxxx, 1'bx, 1'bx, rdy, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
  endtask

  initial begin
    valid_out = 1'b0; alu = '0; zero = 1'b0; carry = 1'b0;
    rsp_ready = 1'b0; clr_stats = 1'b0; reset = 1'b1;
    m_rc = '0; m_zc = '0; m_cc = '0; m_dc = '0; m_ov = 1'b0;

    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);

    // single push, one-cycle latency
    cyc(1'b1, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lat_data", 32'(rsp_data), 32'h2A);
    chk("lat_rc", 32'(result_count), 32'd1);
    idle(1'b0);
    drain();

    // overfill, then drain in order
    for (int i = 1; i <= 5; i++)
      cyc(1'b1, 4'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_drop", 32'(drop_count), 32'd1);
    drain();

    // full with simultaneous push and pop
    for (int i = 1; i <= 4; i++)
      cyc(1'b1, 4'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 4'h7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("pp_level", 32'(level), 32'd4);
    drain();

    // streaming with pointer wrap
    for (int i = 0; i < 20; i++)
      cyc(1'b1, 4'(i), (i % 16) == 0, i[0], 1'b1, 1'b0, 1'b0);
    drain();

    // reset with level 3 and overflow set
    for (int i = 1; i <= 5; i++)
      cyc(1'b1, 4'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    chk("pre_rst_level", 32'(level), 32'd3);
    cyc(1'b1, 4'h9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("post_rst_ovf", 32'(overflow), 32'd0);

    // clear in the same cycle as a push, then saturation
    cyc(1'b1, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 4'h4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("clr_level", 32'(level), 32'd2);
    chk("clr_rc", 32'(result_count), 32'd0);
    for (int i = 0; i < 300; i++)
      cyc(1'b1, 4'(i), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("rc300", 32'(result_count), 32'd300);
    chk("zc_sat", 32'(zero_count), 32'd255);
    drain();

    // random traffic
    for (int i = 0; i < 200; i++) begin
      logic v;
      v = 1'($urandom_range(0, 2) != 0);
      if (v)
        cyc(1'b1, 4'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), ($urandom_range(0, 15) == 0), 1'b0);
      else
        cyc(1'b0, 4'bxxxx, 1'bx, 1'bx,
            1'($urandom), ($urandom_range(0, 15) == 0), 1'b0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_resp_collector.md
ALU_RESP_COLLECTOR -- requirements
Module: alu_resp_collector

Interface
REQ-001 Parameter DEPTH, default 4: FIFO entry count; SHALL be a power of two, 2..16.
REQ-002 Parameter CNT_W, default 16: width of the result counter.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 valid_out  input  1  ALU result strobe; qualifies alu/zero/carry in the same cycle.
REQ-006 alu  input  4  ALU result.
REQ-007 zero  input  1  ALU zero flag.
REQ-008 carry  input  1  ALU carry flag.
REQ-009 clr_stats  input  1  synchronous clear of the statistics counters and the sticky flag only.
REQ-010 rsp_valid  output  1  FIFO head entry available.
REQ-011 rsp_ready  input  1  consumer accepts the head entry when rsp_valid=1.
REQ-012 rsp_data  output  6  head entry, packed as {carry, zero, alu[3:0]}.
REQ-013 level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
REQ-014 full, empty  output  1 each  level==DEPTH and level==0 respectively.
REQ-015 result_count  output  CNT_W  accepted results, saturating.
REQ-016 zero_count, carry_count  output  8 each  accepted results with zero=1 and with carry=1, saturating.
REQ-017 drop_count  output  8  dropped results, saturating.
REQ-018 overflow  output  1  sticky; set when any result is dropped.

Function
REQ-019 Push: valid_out=1 SHALL write {carry,zero,alu} at the write pointer when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-020 Pop: rsp_valid && rsp_ready SHALL advance the read pointer; rsp_data SHALL show the next entry in the following cycle.
REQ-021 rsp_valid SHALL equal !empty; rsp_data SHALL be driven combinationally from the head entry; rsp_data SHALL be don't-care when empty.
REQ-022 Latency: a result pushed into an empty FIFO SHALL appear on rsp_valid/rsp_data exactly one cycle after its valid_out cycle; there SHALL be no same-cycle bypass.
REQ-023 Empty with push and rsp_ready both 1: push accepted, no pop, level becomes 1.
REQ-024 Full with push and pop both 1: both occur, level stays DEPTH, no drop.
REQ-025 Full with push and no pop: result discarded; drop_count +1 (saturating at 255); overflow set; FIFO contents and pointers unchanged.
REQ-026 Pointers SHALL be $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0; full/empty SHALL be derived from level, not pointer equality alone.
REQ-027 Simultaneous push and pop SHALL leave level unchanged; push alone SHALL add 1 and pop alone SHALL subtract 1.
REQ-028 result_count, zero_count and carry_count SHALL increment only on accepted pushes and SHALL hold at their all-ones value.
REQ-029 When clr_stats=1, all counters and overflow SHALL clear that cycle; an event in the same cycle SHALL NOT be counted; FIFO contents SHALL be unaffected.
REQ-030 valid_out=0 SHALL ignore alu/zero/carry, including X values.

Reset
REQ-031 When reset=1 at a rising edge: pointers=0, level=0, empty=1, full=0, rsp_valid=0, all counters=0, overflow=0.
REQ-032 Reset SHALL take priority over push, pop and clr_stats in the same cycle; in-flight entries SHALL be discarded.
REQ-033 FIFO storage need not be reset; rsp_data SHALL NOT be checked while empty=1.

Verification
REQ-034 Reset, then push alu=4'hA, zero=0, carry=1 with rsp_ready=0 -> next cycle: rsp_valid=1, rsp_data=6'b10_1010, level=1, result_count=1, carry_count=1.
REQ-035 Push 4 results (alu=1,2,3,4) with rsp_ready=0, then a fifth (alu=5) -> full=1, drop_count=1, overflow=1; draining returns 1,2,3,4 in order, then empty=1.
REQ-036 Full FIFO, push alu=7 and pop in the same cycle -> level stays 4, drop_count unchanged; alu=7 is delivered last.
REQ-037 Continuous push and rsp_ready=1 for 20 cycles with alu cycling 0..F -> every value delivered once, in order, one cycle late; pointers wrap several times; zero_count counts the alu=0 cases flagged zero=1.
REQ-038 Assert reset with level=3 and overflow=1 while push and pop are active -> next cycle: level=0, empty=1, all counters 0, overflow=0.
REQ-039 clr_stats=1 in the same cycle as an accepted push -> counters 0 and level +1; 300 accepted pushes -> result_count=300, zero_count holds at 255 when every push has zero=1.
